// File: rtl/iq_mod_if.sv
// Bundle of the iq_mod sample handshake, control and passband output signals.
// in_valid/in_ready: a sample transfers on a clock edge where both are 1; in_valid must not depend on in_ready.
interface iq_mod_if #(
  parameter int INPUT_WIDTH  = 12,
  parameter int PHASE_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 12
);
  logic [15:0]              N;
  logic [PHASE_WIDTH-1:0]   Fre_word;
  logic [INPUT_WIDTH-1:0]   I_IN;
  logic [INPUT_WIDTH-1:0]   Q_IN;
  logic                     in_valid;
  logic                     in_ready;
  logic [OUTPUT_WIDTH-1:0]  wave_out;
  logic                     out_valid;
  logic                     underrun;
  logic [1:0]               dbg_state;

  modport slave (
    input  N, Fre_word, I_IN, Q_IN, in_valid,
    output in_ready, wave_out, out_valid, underrun, dbg_state
  );

  modport master (
    output N, Fre_word, I_IN, Q_IN, in_valid,
    input  in_ready, wave_out, out_valid, underrun, dbg_state
  );
endinterface

// File: rtl/iq_mod.sv
// IQ upconverter: zero-order-hold interpolation, quarter-wave NCO, I*cos - Q*sin.
// Define IQ_MOD_ROUND_EN for round-half-up with saturation; default build truncates.
module iq_mod #(
  parameter int INPUT_WIDTH  = 12,
  parameter int LO_WIDTH     = 12,
  parameter int PHASE_WIDTH  = 32,
  parameter int LUT_AW       = 8,
  parameter int OUTPUT_WIDTH = 12
) (
  input logic     clk_in,
  input logic     RST,
  iq_mod_if.slave bus
);
  localparam int PROD_W = INPUT_WIDTH + LO_WIDTH;
  localparam int FULL_W = INPUT_WIDTH + LO_WIDTH + 1;
  localparam int SHIFT  = FULL_W - OUTPUT_WIDTH;
  localparam int DEPTH  = 1 << LUT_AW;
  localparam int IDX_W  = LUT_AW + 2;
  localparam int ADR_W  = LUT_AW + 1;
  localparam real PI    = 3.14159265358979323846;
  localparam real PEAK  = real'((1 << (LO_WIDTH - 1)) - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] STARVE = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [15:0]                    cnt_q, cnt_d;
  logic [15:0]                    n_eff;
  logic                           hold_full_q, hold_full_d;
  logic signed [INPUT_WIDTH-1:0]  hold_i_q, hold_q_q, hold_i_d, hold_q_d;
  logic signed [INPUT_WIDTH-1:0]  act_i_q, act_q_q, act_i_d, act_q_d;
  logic                           underrun_q, underrun_d;
  logic                           load, accept, in_ready;
  logic [PHASE_WIDTH-1:0]         phase_q;
  logic [IDX_W-1:0]               sin_idx, cos_idx;
  logic signed [LO_WIDTH-1:0]     cos_q, sin_q, cos_d, sin_d, cos_mag, sin_mag;
  logic signed [PROD_W-1:0]       prod_i_q, prod_q_q, prod_i_d, prod_q_d;
  logic                           prod_v_q;
  logic signed [FULL_W-1:0]       sum_full;
  logic signed [OUTPUT_WIDTH-1:0] wave_q, wave_d;
  logic                           out_valid_q;

  // First quadrant of sin(x), entries 0..DEPTH inclusive so that sin(pi/2) is exactly the peak.
  function automatic int lut_entry(int g);
    real x;
    x = PEAK * $sin(PI / 2.0 * real'(g) / real'(DEPTH));
    return $rtoi(x + 0.5);
  endfunction

  logic signed [LO_WIDTH-1:0] lut [0:DEPTH];
  for (genvar g = 0; g <= DEPTH; g++) begin : g_lut
    localparam int VAL = lut_entry(g);
    assign lut[g] = LO_WIDTH'(VAL);
  end

  function automatic logic [ADR_W-1:0] quarter_addr(input logic [IDX_W-1:0] idx);
    logic [ADR_W-1:0] a;
    a = {1'b0, idx[LUT_AW-1:0]};
    return idx[LUT_AW] ? (ADR_W'(DEPTH) - a) : a;
  endfunction

  // Sample handshake and hold/active control
  assign n_eff    = (bus.N == 16'd0) ? 16'd1 : bus.N;
  assign in_ready = ~hold_full_q | load;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    load       = 1'b0;
    case (state_q)
      IDLE, STARVE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == 16'd0) begin
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d    = STARVE;
            underrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) cnt_d = n_eff - 16'd1;
  end

  always_comb begin
    hold_full_d = hold_full_q;
    hold_i_d    = hold_i_q;
    hold_q_d    = hold_q_q;
    act_i_d     = act_i_q;
    act_q_d     = act_q_q;
    if (load) begin
      act_i_d     = hold_i_q;
      act_q_d     = hold_q_q;
      hold_full_d = 1'b0;
    end else if (state_d != RUN) begin
      act_i_d = '0;
      act_q_d = '0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
      hold_i_d    = bus.I_IN;
      hold_q_d    = bus.Q_IN;
    end
  end

  // NCO: cos is sin advanced by a quarter turn
  assign sin_idx = phase_q[PHASE_WIDTH-1 -: IDX_W];
  assign cos_idx = sin_idx + IDX_W'(DEPTH);

  always_comb begin
    sin_mag = lut[quarter_addr(sin_idx)];
    cos_mag = lut[quarter_addr(cos_idx)];
    sin_d   = sin_idx[IDX_W-1] ? -sin_mag : sin_mag;
    cos_d   = cos_idx[IDX_W-1] ? -cos_mag : cos_mag;
  end

  assign prod_i_d = act_i_q * cos_q;
  assign prod_q_d = act_q_q * sin_q;
  assign sum_full = FULL_W'(prod_i_q) - FULL_W'(prod_q_q);

`ifdef IQ_MOD_ROUND_EN
  localparam int RW = FULL_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
  localparam logic signed [RW-1:0] OMAX = RW'((1 << (OUTPUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] OMIN = ~OMAX;
  logic signed [RW-1:0] rnd, scaled;

  always_comb begin
    rnd    = RW'(sum_full) + HALF;
    scaled = rnd >>> SHIFT;
    if (scaled > OMAX)      wave_d = OUTPUT_WIDTH'(OMAX);
    else if (scaled < OMIN) wave_d = OUTPUT_WIDTH'(OMIN);
    else                    wave_d = OUTPUT_WIDTH'(scaled);
  end
`else
  assign wave_d = OUTPUT_WIDTH'(sum_full >>> SHIFT);
`endif

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      act_i_q     <= '0;
      act_q_q     <= '0;
      underrun_q  <= 1'b0;
      phase_q     <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      prod_i_q    <= '0;
      prod_q_q    <= '0;
      prod_v_q    <= 1'b0;
      wave_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
      act_i_q     <= act_i_d;
      act_q_q     <= act_q_d;
      underrun_q  <= underrun_d;
      phase_q     <= phase_q + bus.Fre_word;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      prod_i_q    <= prod_i_d;
      prod_q_q    <= prod_q_d;
      prod_v_q    <= (state_q == RUN);
      wave_q      <= wave_d;
      out_valid_q <= prod_v_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.wave_out  = wave_q;
  assign bus.out_valid = out_valid_q;
  assign bus.underrun  = underrun_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_iq_mod.sv
// Directed-plus-random bench for iq_mod against a transaction-level reference model.
module tb_iq_mod;
  localparam int IW = 12, LW = 12, PW = 32, AW = 8, OW = 12;
  localparam int SHIFT = IW + LW + 1 - OW;
  localparam int PEAK = (1 << (LW - 1)) - 1;
  localparam int LUT_BITS = AW + 2;
  localparam real PI = 3.14159265358979323846;

  typedef struct { int i; int q; } samp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iq_mod_if #(.INPUT_WIDTH(IW), .PHASE_WIDTH(PW), .OUTPUT_WIDTH(OW)) bus ();

  iq_mod #(
    .INPUT_WIDTH(IW), .LO_WIDTH(LW), .PHASE_WIDTH(PW), .LUT_AW(AW), .OUTPUT_WIDTH(OW)
  ) dut (
    .clk_in(clk),
    .RST(rst_n),
    .bus(bus)
  );

  // Reference model: a one-deep queue of waiting samples, the sample on air and how many clocks it has left.
  samp_t hold_m[$];
  int m_ai, m_aq, m_left;
  bit m_run, m_under;
  logic [PW-1:0] m_phase;
  logic [PW-1:0] ph_h[$];
  int ai_h[$], aq_h[$];
  bit run_h[$];
  int cyc_n = 0;
  int load_cyc = -1;
  bit last_ov, last_rdy, last_acc;
  int last_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lo_val(input logic [PW-1:0] ph, input bit is_cos);
    real ang, v;
    int idx;
    idx = int'(ph >> (PW - LUT_BITS));
    ang = 2.0 * PI * real'(idx) / real'(1 << LUT_BITS);
    v = real'(PEAK) * (is_cos ? $cos(ang) : $sin(ang));
    return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
  endfunction

  function automatic logic [OW-1:0] wave_ref(input int ai, input int aq, input logic [PW-1:0] ph);
    int full;
    full = ai * lo_val(ph, 1'b1) - aq * lo_val(ph, 1'b0);
    return OW'(full >>> SHIFT);
  endfunction

  task automatic model_reset();
    hold_m.delete();
    ph_h.delete(); ai_h.delete(); aq_h.delete(); run_h.delete();
    for (int k = 0; k < 3; k++) begin
      ph_h.push_back('0); ai_h.push_back(0); aq_h.push_back(0); run_h.push_back(1'b0);
    end
    m_ai = 0; m_aq = 0; m_left = 0; m_run = 1'b0; m_under = 1'b0;
    m_phase = '0;
    load_cyc = -1;
  endtask

  // One clock: check outputs mid-cycle, advance the model across the edge, return 1 after the edge.
  task automatic cyc();
    bit load, ready_e, acc;
    samp_t s;
    @(negedge clk);
    cyc_n++;
    ph_h.push_back(m_phase); ai_h.push_back(m_ai); aq_h.push_back(m_aq); run_h.push_back(m_run);
    if (ph_h.size() > 4) begin
      void'(ph_h.pop_front()); void'(ai_h.pop_front()); void'(aq_h.pop_front()); void'(run_h.pop_front());
    end
    load    = (hold_m.size() != 0) && (!m_run || m_left == 1);
    ready_e = (hold_m.size() == 0) || load;
    acc     = bus.in_valid && ready_e;
    chk("wave_out", 32'(bus.wave_out), 32'(wave_ref(ai_h[1], aq_h[1], ph_h[0])));
    chk("out_valid", 32'(bus.out_valid), 32'(run_h[1]));
    chk("underrun", 32'(bus.underrun), 32'(m_under));
    chk("in_ready", 32'(bus.in_ready), 32'(ready_e));
    last_ov  = bus.out_valid;
    last_w   = int'($signed(bus.wave_out));
    last_rdy = bus.in_ready;
    last_acc = bus.in_valid && bus.in_ready;
    m_phase = m_phase + bus.Fre_word;
    if (load) begin
      s = hold_m.pop_front();
      m_ai = s.i; m_aq = s.q;
      m_left = (bus.N == 16'd0) ? 1 : int'(bus.N);
      m_run = 1'b1;
      if (load_cyc < 0) load_cyc = cyc_n;
    end else if (m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run = 1'b0; m_under = 1'b1; m_ai = 0; m_aq = 0;
      end
    end
    if (acc) begin
      s.i = int'($signed(bus.I_IN));
      s.q = int'($signed(bus.Q_IN));
      hold_m.push_back(s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic drive_rand(input int valid_pct);
    bus.I_IN = IW'($urandom_range(0, (1 << IW) - 1));
    bus.Q_IN = IW'($urandom_range(0, (1 << IW) - 1));
    bus.in_valid = ($urandom_range(1, 100) <= valid_pct);
  endtask

  initial begin
    int pat[4];
    int wq[$];
    int off, nr, na;
    bit seen_ov;
    pat[0] = 511; pat[1] = 0; pat[2] = -512; pat[3] = 0;

    // Reset with a sample offered
    bus.N = 16'd4; bus.Fre_word = '0; bus.I_IN = 12'h123; bus.Q_IN = 12'h456; bus.in_valid = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wave", 32'(bus.wave_out), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_underrun", 32'(bus.underrun), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // fs/4 carrier with a constant full-scale I
    bus.N = 16'd4; bus.Fre_word = 32'h4000_0000; bus.I_IN = 12'h7FF; bus.Q_IN = '0; bus.in_valid = 1'b1;
    restart();
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (last_ov) wq.push_back(last_w);
    end
    chk("fs4_count", 32'(wq.size() >= 8), 32'd1);
    off = -1;
    if (wq.size() >= 8)
      for (int o = 0; o < 4; o++)
        if (pat[o] == wq[0] && pat[(o + 1) % 4] == wq[1]) off = o;
    chk("fs4_align", 32'(off >= 0), 32'd1);
    if (off < 0) off = 0;
    for (int k = 0; k < 8 && k < wq.size(); k++) chk("fs4_pattern", 32'(wq[k]), 32'(pat[(k + off) % 4]));

    // Backpressure with N=4 and in_valid held
    bus.N = 16'd4; bus.Fre_word = $urandom;
    restart();
    for (int k = 0; k < 8; k++) begin drive_rand(100); cyc(); end
    nr = 0; na = 0;
    for (int k = 0; k < 16; k++) begin
      drive_rand(100); cyc();
      nr += int'(last_rdy); na += int'(last_acc);
    end
    chk("bp_ready_count", 32'(nr), 32'd4);
    chk("bp_accept_count", 32'(na), 32'd4);

    // Random segments: varied N, carrier and offered load
    restart();
    for (int seg = 0; seg < 5; seg++) begin
      int pct;
      bus.N = 16'($urandom_range(0, 6));
      bus.Fre_word = $urandom;
      pct = $urandom_range(20, 100);
      for (int k = 0; k < 40; k++) begin drive_rand(pct); cyc(); end
    end

    // Underrun after a single sample at N=8
    bus.N = 16'd8; bus.Fre_word = $urandom;
    restart();
    drive_rand(100); bus.in_valid = 1'b1; cyc();
    bus.in_valid = 1'b0;
    repeat (15) cyc();
    chk("ur_wave", 32'(bus.wave_out), 32'd0);
    chk("ur_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ur_flag", 32'(bus.underrun), 32'd1);
    seen_ov = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive_rand(100); cyc();
      seen_ov |= last_ov;
    end
    chk("ur_persist", 32'(bus.underrun), 32'd1);
    chk("ur_resume_valid", 32'(seen_ov), 32'd1);

    // N=0 behaves as N=1: accept every clock
    bus.N = 16'd0; bus.Fre_word = $urandom;
    restart();
    nr = 0; na = 0;
    for (int k = 0; k < 12; k++) begin
      drive_rand(100); cyc();
      nr += int'(last_rdy); na += int'(last_acc);
    end
    chk("n0_ready_count", 32'(nr), 32'd12);
    chk("n0_accept_count", 32'(na), 32'd12);

    // Reset pulsed in the middle of a held sample
    bus.N = 16'd5; bus.Fre_word = $urandom;
    restart();
    for (int k = 0; k < 13; k++) begin drive_rand(100); cyc(); end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wave", 32'(bus.wave_out), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_underrun", 32'(bus.underrun), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    bus.I_IN = 12'h5A5; bus.Q_IN = 12'h3C3; bus.in_valid = 1'b1;
    seen_ov = 1'b0;
    for (int k = 0; k < 10 && !seen_ov; k++) begin
      cyc();
      seen_ov = last_ov;
    end
    chk("post_rst_seen", 32'(seen_ov), 32'd1);
    chk("post_rst_latency", 32'(cyc_n - load_cyc), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/iq_mod.md
IQ_MOD -- requirements
Module: iq_mod

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 12, the signed I/Q baseband sample width.
REQ-002 SHALL have parameter LO_WIDTH, default 12, the signed LO (cos/sin) sample width.
REQ-003 SHALL have parameter PHASE_WIDTH, default 32, the NCO phase accumulator width.
REQ-004 SHALL have parameter LUT_AW, default 8, the quarter-wave sine table address width.
REQ-005 SHALL have parameter OUTPUT_WIDTH, default 12, the signed passband output width.
REQ-006 SHALL have clk_in, input, 1, the single clock for all logic.
REQ-007 SHALL have RST, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have N, input, 16, the interpolation ratio, i.e. output clocks per baseband sample.
REQ-009 SHALL have Fre_word, input, PHASE_WIDTH, the NCO phase increment per clock.
REQ-010 SHALL have I_IN, input, INPUT_WIDTH, the signed in-phase sample.
REQ-011 SHALL have Q_IN, input, INPUT_WIDTH, the signed quadrature sample.
REQ-012 SHALL have in_valid, input, 1, meaning I_IN/Q_IN are valid.
REQ-013 SHALL have in_ready, output, 1, meaning the block can accept a sample.
REQ-014 SHALL have wave_out, output, OUTPUT_WIDTH, the signed modulated passband sample.
REQ-015 SHALL have out_valid, output, 1, meaning wave_out carries modulated data.
REQ-016 SHALL have underrun, output, 1, a sticky starvation flag.

Function
REQ-017 SHALL accept a sample on any clock where in_valid=1 and in_ready=1, storing it in a one-entry hold register.
REQ-018 SHALL drive in_ready=1 exactly when the hold register is empty; a same-cycle load of the hold register into the active register plus a new accept SHALL be allowed.
REQ-019 SHALL implement states IDLE, RUN and STARVE.
- IDLE to RUN: when the hold register is full.
- RUN to RUN: counter at 0 and hold full.
- RUN to STARVE: counter at 0 and hold empty.
- STARVE to RUN: when the hold register is full.
REQ-020 SHALL, on every transition into RUN and on each RUN-to-RUN reload, move the hold register to the active register and load the down-counter with N-1, with N=0 treated as N=1.
REQ-021 SHALL decrement the counter once per clock in RUN; each active sample is held for exactly N clocks (zero-order hold).
REQ-022 SHALL use the value 0 for the active I/Q in IDLE and STARVE, and set underrun=1 on entry to STARVE; underrun stays 1 until reset.
REQ-023 SHALL advance the phase accumulator by Fre_word every clock in all states, wrapping modulo 2^PHASE_WIDTH.
REQ-024 SHALL derive cos and sin from the top LUT_AW+2 phase bits via a quarter-wave table with peak 2^(LO_WIDTH-1)-1, using quadrant symmetry.
REQ-025 SHALL compute I*cos - Q*sin at full width INPUT_WIDTH+LO_WIDTH+1 and output its top OUTPUT_WIDTH bits.
REQ-026 SHALL use a three-register pipeline (LO register, product register, sum/output register); an active sample loaded at cycle t first affects wave_out at cycle t+3.
REQ-027 SHALL drive out_valid=1 three clocks after the corresponding active data is in RUN, and 0 otherwise, so that out_valid stays aligned with wave_out.

Reset
REQ-028 SHALL, while RST=0, asynchronously clear the phase accumulator, counter, hold and active registers, pipeline, out_valid, underrun and wave_out to 0, set state to IDLE, and set in_ready=1.
REQ-029 SHALL discard any in-flight sample on reset mid-operation, and resume from IDLE on the first clock after RST rises.

Configuration
REQ-030 SHALL, with macro IQ_MOD_ROUND_EN defined, add half an output LSB before truncation and saturate to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
REQ-031 SHALL, without IQ_MOD_ROUND_EN, truncate only, with no saturation logic present.

Verification
REQ-032 SHALL cover reset: RST=0 with in_valid=1 -> wave_out=0, out_valid=0, underrun=0, in_ready=1.
REQ-033 SHALL cover a fs/4 carrier: I=0x7FF, Q=0, Fre_word=0x40000000, N=4, in_valid held, macro undefined -> wave_out repeats 511, 0, -512, 0.
REQ-034 SHALL cover backpressure: N=4, in_valid held -> in_ready high one clock in every 4, and exactly one accept per 4 clocks.
REQ-035 SHALL cover underrun: N=8, one sample sent and then in_valid=0 -> after 8 output clocks wave_out=0, out_valid=0, underrun=1, and underrun persists when samples resume.
REQ-036 SHALL cover N=0: N=0 with in_valid held -> in_ready stays 1 and a new sample is accepted every clock.
REQ-037 SHALL cover reset mid-run: RST pulsed low mid-sample -> all outputs are 0 immediately, and the first post-reset sample appears on wave_out 3 clocks after its load.
